// File: rtl/uart_mem_bridge.sv
// UART-to-memory command bridge: opcode byte plus BYTES payload bytes in, BYTES-byte response out (MSB first).
// Define UART_BRIDGE_TIMEOUT_EN to discard partial frames after TIMEOUT_CYCLES idle cycles.
module uart_mem_bridge #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_ready,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     wr_d,
    output logic [DATA_W/8-1:0]   wr_byte_en,
    output logic                  wr_req,
    output logic                  rd_req,
    output logic [5:0]            rd_num_dwords,
    input  logic [DATA_W-1:0]     rd_d,
    input  logic                  rd_rdy,
    input  logic                  busy,
    output logic                  err
);
    localparam int BYTES = DATA_W / 8;

    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 64 || ADDR_W < 1 || ADDR_W > DATA_W ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_mem_bridge: unsupported parameter combination");
    end

    typedef enum logic [2:0] {RX, EXEC, MEM_ISSUE, MEM_WAIT, TX, TX_HOLD} state_t;
    state_t state, state_nxt;

    logic [7:0]        opcode;
    logic [DATA_W-1:0] payload;
    logic [DATA_W-1:0] resp;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] rdata;
    logic [3:0]        rx_cnt;
    logic [3:0]        tx_cnt;
    logic              mem_op, is_read, is_inc, bad_op;
    logic              frame_done;
    logic              timeout;

    always_comb begin
        mem_op  = 1'b0;
        is_read = 1'b0;
        is_inc  = 1'b0;
        bad_op  = 1'b0;
        case (opcode)
            8'h01, 8'h02, 8'h04, 8'h06, 8'h07, 8'h08: ;
            8'h03: mem_op = 1'b1;
            8'h05: begin mem_op = 1'b1; is_read = 1'b1; end
            8'h09: begin mem_op = 1'b1; is_inc = 1'b1; end
            8'h0A: begin mem_op = 1'b1; is_read = 1'b1; is_inc = 1'b1; end
            default: bad_op = 1'b1;
        endcase
    end

    assign frame_done = (state == RX) && rx_valid && (rx_cnt == 4'(BYTES));

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap;

    always_ff @(posedge clk) begin
        if (reset || rx_valid || state != RX || rx_cnt == '0 || timeout)
            gap <= '0;
        else
            gap <= gap + GAP_W'(1);
    end

    assign timeout = (state == RX) && !rx_valid && (rx_cnt != '0) &&
                     (gap == GAP_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= RX;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX:        if (frame_done) state_nxt = EXEC;
            EXEC:      state_nxt = mem_op ? MEM_ISSUE : TX;
            MEM_ISSUE: if (!busy) state_nxt = is_read ? MEM_WAIT : TX;
            MEM_WAIT:  if (rd_rdy) state_nxt = TX;
            TX:        if (tx_ready) state_nxt = TX_HOLD;
            TX_HOLD:   state_nxt = (tx_cnt == 4'(BYTES)) ? RX : TX;
            default:   state_nxt = RX;
        endcase
    end

    // Strobes are gated by reset so nothing escapes while a command is being abandoned.
    always_comb begin
        tx_start = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        if (!reset) begin
            case (state)
                MEM_ISSUE: begin
                    wr_req = !busy && !is_read;
                    rd_req = !busy && is_read;
                end
                TX:      tx_start = tx_ready;
                default: ;
            endcase
        end
    end

    assign tx_data       = resp[DATA_W-1 -: 8];
    assign rd_num_dwords = 6'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            wr_d       <= '0;
            wr_byte_en <= '1;
            err        <= 1'b0;
            count      <= '0;
            rdata      <= '0;
            resp       <= '0;
            opcode     <= '0;
            payload    <= '0;
            rx_cnt     <= '0;
            tx_cnt     <= '0;
        end else begin
            err <= (rx_valid && state != RX) || (state == EXEC && bad_op) || timeout;

            if (state == RX && rx_valid) begin
                if (rx_cnt == '0)
                    opcode <= rx_data;
                else
                    payload <= (payload << 8) | DATA_W'(rx_data);
                rx_cnt <= frame_done ? '0 : rx_cnt + 4'd1;
            end else if (timeout) begin
                rx_cnt <= '0;
            end

            case (state)
                EXEC: begin
                    tx_cnt <= '0;
                    case (opcode)
                        8'h01: begin addr <= payload[ADDR_W-1:0]; resp <= payload; end
                        8'h02: begin wr_d <= payload; resp <= payload; end
                        8'h03, 8'h09: resp <= DATA_W'(3);
                        8'h04: resp <= rdata;
                        8'h05, 8'h0A: ;
                        8'h06: begin resp <= count; count <= count + DATA_W'(1); end
                        8'h07: resp <= {BYTES{8'h01}};
                        8'h08: begin wr_byte_en <= payload[BYTES-1:0]; resp <= payload; end
                        default: resp <= '1;
                    endcase
                end
                MEM_ISSUE: begin
                    if (!busy && !is_read && is_inc)
                        addr <= addr + ADDR_W'(1);
                end
                MEM_WAIT: begin
                    if (rd_rdy) begin
                        rdata <= rd_d;
                        resp  <= rd_d;
                        if (is_inc)
                            addr <= addr + ADDR_W'(1);
                    end
                end
                TX: begin
                    if (tx_ready) begin
                        resp   <= resp << 8;
                        tx_cnt <= tx_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Generalised UART-to-memory command bridge. Sits between uart_rx/uart_tx and hyper_xface on the hram_clk domain.
- Assembles framed commands: one opcode byte, then BYTES payload bytes, MSB first.
- Executes each command as a register update or a memory transaction.
- Returns a BYTES-wide response once the command completes, not byte-echoed during reception.

Parameters:
- DATA_W, 32, memory data width in bits; multiple of 8, range 8..64. BYTES = DATA_W/8 (derived localparam).
- ADDR_W, 32, address width; must be <= DATA_W.
- TIMEOUT_CYCLES, 4096, inter-byte gap limit (used only with UART_BRIDGE_TIMEOUT_EN).

Ports:
- clk  in  1  bridge/memory clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe: rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit strobe
- tx_ready  in  1  transmitter idle
- addr  out  ADDR_W  memory address
- wr_d  out  DATA_W  write data
- wr_byte_en  out  BYTES  write byte enables
- wr_req  out  1  one-cycle write request
- rd_req  out  1  one-cycle read request
- rd_num_dwords  out  6  constant 1
- rd_d  in  DATA_W  read data
- rd_rdy  in  1  one-cycle read-data-valid strobe
- busy  in  1  memory controller busy
- err  out  1  one-cycle error strobe

Behaviour:
- Single clock clk; reset synchronous, active-high.
- Reset values: tx_data=0, tx_start=0, addr=0, wr_d=0, wr_byte_en=all ones, wr_req=0, rd_req=0, err=0, count=0, rdata=0, state=RX, byte counter=0.
- A reset in any state abandons the command. No wr_req, rd_req or tx_start is issued after the reset cycle.
- States:
  - RX: collect bytes; go to EXEC on the cycle after the last payload byte's rx_valid.
  - EXEC: decode the command.
  - MEM_ISSUE: wait for busy=0, then pulse wr_req/rd_req for 1 cycle.
  - MEM_WAIT: reads only; wait for rd_rdy, capturing rd_d into rdata.
  - TX: pulse tx_start when tx_ready=1.
  - TX_HOLD: 1 cycle ignoring tx_ready, then back to TX until BYTES bytes sent, then RX.
- Response is sent MSB byte first.
- rx_valid outside RX: byte dropped, err pulse the same cycle +1.
- Opcodes (payload = P):
  - 0x01 ADDR: addr<=P[ADDR_W-1:0]; response P.
  - 0x02 LOAD: wr_d<=P; response P.
  - 0x03 WRITE: write wr_d at addr with wr_byte_en; response 0x03, zero-extended.
  - 0x04 READ: response rdata (last captured).
  - 0x05 READ_REQ: read at addr; response is the new rdata.
  - 0x06 COUNT: response count, then count<=count+1 (wraps at 2^DATA_W).
  - 0x07 CONST: response 0x01 replicated BYTES times.
  - 0x08 BYTE_EN: wr_byte_en<=P[BYTES-1:0]; response P.
  - 0x09 WRITE_INC: as WRITE, then addr<=addr+1 (mod 2^ADDR_W) the cycle after wr_req.
  - 0x0A READ_INC: as READ_REQ, then addr<=addr+1 (mod 2^ADDR_W) the cycle after rd_rdy.
  - Other: response all ones; err pulse in EXEC.
- Latency, non-memory command: last-byte rx_valid at cycle N; tx_start at N+2 if tx_ready=1.
- Memory command with busy=0 at EXEC exit: request at N+2.
- wr_req/rd_req are never asserted while busy=1. Never more than one outstanding request.
- rd_rdy outside MEM_WAIT: ignored.
- addr, wr_d and wr_byte_en are stable from request until the next command's EXEC.

Optional Feature:
- Macro: UART_BRIDGE_TIMEOUT_EN.
- Defined: in RX with a partial frame (byte counter >0), TIMEOUT_CYCLES consecutive cycles without rx_valid clears the counter, discards the partial frame and pulses err. Gap counter resets on each rx_valid.
- Undefined: a partial frame is held indefinitely; no timeout logic is synthesised.

Test Plan:
- Reset, then frame 01 00 00 00 2A -> addr=0x2A; response bytes 00 00 00 2A; 4 tx_start pulses.
- LOAD DEADBEEF, then WRITE_INC with busy held high 5 cycles -> single wr_req after busy falls, wr_d=0xDEADBEEF, addr 0x2A→0x2B; response 00 00 00 03.
- ADDR 0x2A, READ_INC, rd_rdy with rd_d=0xCAFEF00D 7 cycles after rd_req -> response CA FE F0 0D; addr=0x2B; subsequent READ returns same bytes.
- COUNT ×3 -> responses 0,1,2; opcode 0x55 -> response FF FF FF FF plus one err pulse.
- Byte arriving during TX -> dropped, err pulse, following frame parsed correctly. Reset asserted in MEM_WAIT -> no further pulses, all outputs at reset values.
- With UART_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 2 bytes, idle 16 cycles -> err pulse; the next full 5-byte CONST frame yields 01 01 01 01.
